// File: rtl/amber48_pkg.sv
// Shared amber48 constants and request payloads for the register file with scoreboard.
package amber48_pkg;

  localparam int unsigned AMBER48_XLEN      = 48;
  localparam int unsigned AMBER48_REG_COUNT = 16;
  localparam int unsigned AMBER48_AW        = $clog2(AMBER48_REG_COUNT);
  localparam int unsigned AMBER48_NUM_READ  = 2;

  typedef struct packed {
    logic                  valid;
    logic [AMBER48_AW-1:0] addr;
  } amber48_rsv_req_s;

  typedef struct packed {
    logic                    valid;
    logic [AMBER48_AW-1:0]   addr;
    logic [AMBER48_XLEN-1:0] data;
  } amber48_wb_req_s;

  // Regfile request sized by the default read-port count.
  typedef struct packed {
    logic [AMBER48_NUM_READ-1:0][AMBER48_AW-1:0] rd_addr;
    amber48_rsv_req_s                            rsv;
    amber48_wb_req_s                             wb;
    logic                                        flush;
  } amber48_rf_req_s;

endpackage

// File: rtl/amber48_scoreboard.sv
// Per-register in-flight destination tracking: busy vector, reservation
// acceptance, flush and spurious-writeback detection.
module amber48_scoreboard
  import amber48_pkg::*;
#(
  parameter int unsigned REG_COUNT = AMBER48_REG_COUNT,
  parameter int unsigned ZERO_REG  = 1,
  localparam int unsigned AW       = $clog2(REG_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rsv_valid_i,
  input  logic [AW-1:0]        rsv_addr_i,
  input  logic                 wb_valid_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic                 flush_i,
  output logic                 rsv_ready_o,
  output logic [REG_COUNT-1:0] busy_o,
  output logic                 wb_spurious_o
);

  localparam bit LP_ZERO = (ZERO_REG != 0);

  logic [REG_COUNT-1:0] r_busy;
  logic [REG_COUNT-1:0] w_busy_nxt;
  logic                 r_wb_spurious;
  logic                 w_spurious_nxt;
  logic                 w_rsv_zero;
  logic                 w_wb_zero;

  assign w_rsv_zero = LP_ZERO && (rsv_addr_i == '0);
  assign w_wb_zero  = LP_ZERO && (wb_addr_i == '0);

  assign rsv_ready_o = ~r_busy[rsv_addr_i]
                     | (wb_valid_i && (wb_addr_i == rsv_addr_i))
                     | w_rsv_zero;

  // Writeback clears first so a same-cycle reservation of that register wins.
  always_comb begin
    w_busy_nxt     = r_busy;
    w_spurious_nxt = wb_valid_i && !r_busy[wb_addr_i] && !w_wb_zero;
    if (wb_valid_i) begin
      w_busy_nxt[wb_addr_i] = 1'b0;
    end
    if (rsv_valid_i && rsv_ready_o && !w_rsv_zero) begin
      w_busy_nxt[rsv_addr_i] = 1'b1;
    end
    if (flush_i) begin
      w_busy_nxt = '0;
    end
    if (LP_ZERO) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy        <= '0;
      r_wb_spurious <= 1'b0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_wb_spurious <= w_spurious_nxt;
    end
  end

  assign busy_o        = r_busy;
  assign wb_spurious_o = r_wb_spurious;

endmodule

// File: rtl/amber48_regfile_sb.sv
// amber48 register file with parametrised read ports, writeback bypass,
// optional hardwired r0 and an integrated destination scoreboard.
module amber48_regfile_sb
  import amber48_pkg::*;
#(
  parameter int unsigned XLEN      = AMBER48_XLEN,
  parameter int unsigned REG_COUNT = AMBER48_REG_COUNT,
  parameter int unsigned NUM_READ  = AMBER48_NUM_READ,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned BYPASS    = 1,
  localparam int unsigned AW       = $clog2(REG_COUNT)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_READ*AW-1:0]   rd_addr_i,
  output logic [NUM_READ*XLEN-1:0] rd_data_o,
  output logic [NUM_READ-1:0]      rd_busy_o,
  input  logic                     rsv_valid_i,
  input  logic [AW-1:0]            rsv_addr_i,
  output logic                     rsv_ready_o,
  input  logic                     wb_valid_i,
  input  logic [AW-1:0]            wb_addr_i,
  input  logic [XLEN-1:0]          wb_data_i,
  input  logic                     flush_i,
  output logic [REG_COUNT-1:0]     busy_o,
  output logic                     wb_spurious_o
);

  localparam bit LP_ZERO   = (ZERO_REG != 0);
  localparam bit LP_BYPASS = (BYPASS != 0);

  logic [REG_COUNT-1:0][XLEN-1:0] r_regs;
  logic [REG_COUNT-1:0]           w_busy;
  logic [AW-1:0]                  w_rd_addr;

  amber48_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rsv_valid_i   (rsv_valid_i),
    .rsv_addr_i    (rsv_addr_i),
    .wb_valid_i    (wb_valid_i),
    .wb_addr_i     (wb_addr_i),
    .flush_i       (flush_i),
    .rsv_ready_o   (rsv_ready_o),
    .busy_o        (w_busy),
    .wb_spurious_o (wb_spurious_o)
  );

  // Storage; flush does not suppress writeback data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_regs <= '0;
    end else if (wb_valid_i && !(LP_ZERO && (wb_addr_i == '0))) begin
      r_regs[wb_addr_i] <= wb_data_i;
    end
  end

  // Read ports: hardwired zero, then bypass, then stored state.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    w_rd_addr = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      w_rd_addr = rd_addr_i[i*AW +: AW];
      if (LP_ZERO && (w_rd_addr == '0)) begin
        rd_data_o[i*XLEN +: XLEN] = '0;
        rd_busy_o[i]              = 1'b0;
      end else if (LP_BYPASS && wb_valid_i && (wb_addr_i == w_rd_addr)) begin
        rd_data_o[i*XLEN +: XLEN] = wb_data_i;
        rd_busy_o[i]              = 1'b0;
      end else begin
        rd_data_o[i*XLEN +: XLEN] = r_regs[w_rd_addr];
        rd_busy_o[i]              = w_busy[w_rd_addr];
      end
    end
  end

  assign busy_o = w_busy;

endmodule

// File: doc/amber48_regfile_sb.md
# amber48_regfile_sb

Parametrised successor to the fixed two-read/one-write amber48 register-file request: a register file with a configurable number of read ports, write-to-read bypass, a hardwired zero register, and an integrated per-register scoreboard that tracks in-flight destinations. It sits between decode and execute. Decode reserves a destination at issue. Writeback clears the reservation. Decode stalls on busy sources or busy destinations (WAW).

## Interface
- `XLEN`, 48, data width
- `REG_COUNT`, 16, number of architectural registers; `AW = $clog2(REG_COUNT)`
- `NUM_READ`, 2, number of combinational read ports (1..4)
- `ZERO_REG`, 1, when 1, r0 reads 0, ignores writes and is never busy
- `BYPASS`, 1, when 1, same-cycle writeback data is forwarded to read ports
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_ni`  in  1  reset; asynchronous, active-low
- `rd_addr_i`  in  NUM_READ×AW  read addresses
- `rd_data_o`  out  NUM_READ×XLEN  read data
- `rd_busy_o`  out  NUM_READ  source is pending (not yet written back)
- `rsv_valid_i`  in  1  reserve `rsv_addr_i` as an in-flight destination
- `rsv_addr_i`  in  AW  destination to reserve
- `rsv_ready_o`  out  1  reservation accepted this cycle
- `wb_valid_i`  in  1  writeback strobe
- `wb_addr_i`  in  AW  writeback register
- `wb_data_i`  in  XLEN  writeback data
- `flush_i`  in  1  clears all reservations (pipeline flush / trap)
- `busy_o`  out  REG_COUNT  scoreboard vector
- `wb_spurious_o`  out  1  registered pulse: last cycle's writeback targeted a non-busy register

## Operation
- Storage is `REG_COUNT` × XLEN flops plus a `busy[REG_COUNT]` vector.
- Read port i:
  - if ZERO_REG and addr=0: data 0, busy 0;
  - else if BYPASS, wb_valid_i and wb_addr_i=addr: data=wb_data_i, busy 0;
  - else data=reg[addr], busy=busy[addr].
- Writeback: reg[wb_addr_i] ← wb_data_i and busy[wb_addr_i] ← 0, unless overridden by a reservation in the same cycle. Writes to r0 are dropped when ZERO_REG=1.
- `rsv_ready_o = ~busy[rsv_addr_i] | (wb_valid_i & wb_addr_i==rsv_addr_i) | (ZERO_REG & rsv_addr_i==0)`. The signal is independent of `rsv_valid_i`.
- A reservation is accepted when `rsv_valid_i & rsv_ready_o`. Acceptance sets busy[rsv_addr_i] ← 1. r0 is never set when ZERO_REG=1.
- Same register, writeback and accepted reservation in one cycle: data is written and busy ends at 1.
- `flush_i`: all busy ← 0 next edge. Flush wins over a same-cycle reservation, which is dropped. The same-cycle writeback data is still written.
- `wb_spurious_o` ← wb_valid_i & ~busy[wb_addr_i] & ~(ZERO_REG & wb_addr_i==0). Evaluated on pre-edge state. Sticky for one cycle only.

## Timing
- Reads and `rd_busy_o`/`rsv_ready_o` are combinational; with BYPASS=0 they have zero-cycle visibility of state only.
- Write data visible at reg outputs one cycle after `wb_valid_i`, or same cycle via bypass.
- Busy set/clear visible on `busy_o` one cycle after the causing strobe.
- Reset (async assert, sync-safe deassert externally): all regs 0, busy 0, `wb_spurious_o` 0. `rd_data_o` therefore reads 0.
- Reset mid-operation discards all reservations and data. No pending state survives.

## Structure
- Add to `amber48_pkg`:
  - `AMBER48_NUM_READ` default constant;
  - `amber48_rsv_req_s` {valid, addr};
  - `amber48_wb_req_s` {valid, addr, data};
  - a `NUM_READ`-generic variant of the regfile request struct.
- One sub-module, `amber48_scoreboard`. It owns the busy vector, rsv_ready, flush and spurious detection. The top holds storage and the read/bypass muxes.

## Test plan
- Reset, then read r0..r15 on both ports → all 0, `busy_o`=0, `rsv_ready_o`=1.
- Reserve r5; next cycle read r5 → `rd_busy_o`=1, re-reserve r5 → `rsv_ready_o`=0. Writeback r5=48'h0000_1234_5678 → same cycle bypass data 48'h0000_1234_5678, busy 0. Next cycle `busy_o[5]`=0.
- Writeback r5 with reservation r5 in the same cycle → `rsv_ready_o`=1, r5 holds new data, `busy_o[5]`=1.
- Write r0=48'hFFFF_FFFF_FFFF, reserve r0 → reads 0, `busy_o[0]`=0, `rsv_ready_o`=1, no spurious pulse.
- Reserve r3, r7, r9; assert flush with reservation r2 in the same cycle → `busy_o`=0 next cycle, r2 not busy.
- Writeback r4 when not busy → `wb_spurious_o`=1 for exactly one cycle, r4 still updated. Assert rst_ni low mid-sequence → outputs 0 immediately.
